// File: rtl/ddc_nco_mixer.sv
// DDC mixer: ADC sample times NCO sine, rounded and saturated into the FIR chain.
// A test mode forwards the raw sine; mode changes blank the output while the pipe refills.
module ddc_nco_mixer #(
  parameter int DATA_W    = 16,
  parameter int NCO_W     = 16,
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    din,
  input  logic                 din_valid,
  input  logic [NCO_W-1:0]     sin_val,
  input  logic                 nco_test_en,
  input  logic                 sat_clr,
  output logic [DATA_W-1:0]    dout,
  output logic                 dout_valid,
  output logic                 sat_flag,
  output logic [SAT_CNT_W-1:0] sat_cnt
);
  localparam int PROD_W = DATA_W + NCO_W;
  localparam int SHIFT  = NCO_W - 1;
  localparam int R_W    = PROD_W + 1 - SHIFT;
  localparam int STAGES = 2;

  localparam logic signed [R_W-1:0] R_MAX = {{(R_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [R_W-1:0] R_MIN = {{(R_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [SAT_CNT_W-1:0]  CNT_ONE = {{(SAT_CNT_W-1){1'b0}}, 1'b1};

  // bit 0 is S1, bit 1 is S2; S3 is the dout register itself
  logic [STAGES-1:0]        vld_pipe, mode_pipe;
  logic signed [DATA_W-1:0] d1;
  logic signed [NCO_W-1:0]  s1, s2;
  logic signed [PROD_W-1:0] p2;
  logic                     mode_prev;
  logic [1:0]               flush;

  logic signed [PROD_W:0]   p_rnd;
  logic signed [R_W-1:0]    r;
  logic [DATA_W-1:0]        r_sat;
  logic                     ovf, sat_evt;

  always_comb begin
    p_rnd = $signed({p2[PROD_W-1], p2}) + $signed((PROD_W+1)'(1) << (SHIFT-1));
    r     = p_rnd[PROD_W:SHIFT];
    ovf   = (r > R_MAX) || (r < R_MIN);
    r_sat = r[DATA_W-1:0];
    if (r > R_MAX)      r_sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (r < R_MIN) r_sat = {1'b1, {(DATA_W-1){1'b0}}};
    // samples dropped by a flush never reach dout, so they are not counted
    sat_evt = vld_pipe[1] & ~mode_pipe[1] & (flush == 2'd0) & ovf;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe   <= '0;
      mode_pipe  <= '0;
      d1         <= '0;
      s1         <= '0;
      s2         <= '0;
      p2         <= '0;
      mode_prev  <= 1'b0;
      flush      <= 2'd0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sat_flag   <= 1'b0;
      sat_cnt    <= '0;
    end else begin
      d1        <= $signed(din);
      s1        <= $signed(sin_val);
      vld_pipe  <= {vld_pipe[0], din_valid};
      mode_pipe <= {mode_pipe[0], nco_test_en};
      p2        <= PROD_W'(d1) * PROD_W'(s1);
      s2        <= s1;
      mode_prev <= mode_pipe[0];

      if (mode_pipe[0] != mode_prev) flush <= 2'd3;
      else if (flush != 2'd0)        flush <= flush - 2'd1;

      if (flush != 2'd0) begin
        dout_valid <= 1'b0;
      end else if (mode_pipe[1]) begin
        dout_valid <= 1'b1;
        dout       <= DATA_W'(s2);
      end else begin
        dout_valid <= vld_pipe[1];
        if (vld_pipe[1]) dout <= r_sat;
      end

      // an event in the same cycle as a clear restarts the count at one
      if (sat_evt) begin
        sat_flag <= 1'b1;
        if (sat_clr)                 sat_cnt <= CNT_ONE;
        else if (sat_cnt != '1)      sat_cnt <= sat_cnt + CNT_ONE;
      end else if (sat_clr) begin
        sat_flag <= 1'b0;
        sat_cnt  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ddc_nco_mixer.sv
// Directed bench for ddc_nco_mixer: expected outputs queued at drive time, checked 3 clocks later.
module tb_ddc_nco_mixer;
  logic        clk, rst;
  logic [15:0] din, sin_val, dout;
  logic        din_valid, nco_test_en, sat_clr, dout_valid, sat_flag;
  logic [15:0] sat_cnt;

  ddc_nco_mixer #(.DATA_W(16), .NCO_W(16), .SAT_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sin_val(sin_val),
    .nco_test_en(nco_test_en), .sat_clr(sat_clr), .dout(dout), .dout_valid(dout_valid),
    .sat_flag(sat_flag), .sat_cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit vld; logic [15:0] val; bit sat; } exp_t;
  exp_t q[$];

  int tests = 0, fails = 0;
  bit prev_te = 0;
  int blank = 0;
  logic [15:0] hold = '0;
  int exp_cnt = 0;
  bit exp_flag = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_mix(input int d, input int s, output bit sat);
    longint p, r;
    p = longint'(d) * longint'(s);
    r = (p + 64'sd16384) >>> 15;
    sat = (r > 32767) || (r < -32768);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  task automatic model_reset();
    exp_t z;
    z.vld = 0; z.val = '0; z.sat = 0;
    q.delete();
    q.push_back(z);
    q.push_back(z);
    prev_te = 0; blank = 0; hold = '0; exp_cnt = 0; exp_flag = 0;
  endtask

  task automatic cyc(input int d, input int s, input bit v, input bit te, input bit clr);
    exp_t e;
    bit sb, evt;
    din = 16'(d); sin_val = 16'(s); din_valid = v; nco_test_en = te; sat_clr = clr;
    e.vld = 0; e.val = '0; e.sat = 0;
    if (te != prev_te) blank = 3;
    prev_te = te;
    if (blank > 0) blank--;
    else if (te) begin e.vld = 1; e.val = 16'(s); end
    else if (v) begin e.vld = 1; e.val = ref_mix(d, s, sb); e.sat = sb; end
    q.push_back(e);
    @(posedge clk); #1;
    evt = 0;
    if (q.size() == 3) begin
      e = q.pop_front();
      evt = e.sat;
      if (e.vld) hold = e.val;
      chk("dout_valid", {31'b0, dout_valid}, {31'b0, e.vld});
      chk("dout", {16'b0, dout}, {16'b0, hold});
    end
    if (evt) begin
      exp_flag = 1;
      exp_cnt = clr ? 1 : ((exp_cnt == 65535) ? 65535 : exp_cnt + 1);
    end else if (clr) begin
      exp_flag = 0; exp_cnt = 0;
    end
    chk("sat_flag", {31'b0, sat_flag}, {31'b0, exp_flag});
    chk("sat_cnt", {16'b0, sat_cnt}, 32'(exp_cnt));
  endtask

  initial begin
    rst = 0; din = '0; sin_val = '0; din_valid = 0; nco_test_en = 0; sat_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", {16'b0, dout}, 32'h0);
    chk("rst_dout_valid", {31'b0, dout_valid}, 32'h0);
    chk("rst_sat_flag", {31'b0, sat_flag}, 32'h0);
    chk("rst_sat_cnt", {16'b0, sat_cnt}, 32'h0);
    rst = 1;
    model_reset();

    // mix: unity-ish, rounding, sign, boundary
    cyc(16384, 16384, 1, 0, 0);
    cyc(3, 16384, 1, 0, 0);
    cyc(-3, 16384, 1, 0, 0);
    cyc(-32768, 32767, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("last_dout_m32767", {16'b0, dout}, 32'h0000_8001);

    // valid gaps 1,0,1,1
    cyc(1000, 20000, 1, 0, 0);
    cyc(5, 5, 0, 0, 0);
    cyc(-7000, 12345, 1, 0, 0);
    cyc(32767, 32767, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);

    // saturation, then clear colliding with the 6th event
    repeat (6) cyc(-32768, -32768, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("sat_cnt_5", {16'b0, sat_cnt}, 32'd5);
    chk("sat_dout_max", {16'b0, dout}, 32'h0000_7fff);
    cyc(0, 0, 0, 0, 1);
    chk("sat_cnt_clr_evt", {16'b0, sat_cnt}, 32'd1);
    cyc(0, 0, 0, 0, 1);
    chk("sat_cnt_clr", {16'b0, sat_cnt}, 32'd0);

    // test mode entry with a ramp, then back to mix
    for (int i = 0; i < 10; i++) cyc(100, i, 0, 1, 0);
    cyc(200, 10, 1, 0, 0);
    cyc(200, 11, 0, 0, 0);
    cyc(300, 12, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(400 + i, 8000, i % 2, 0, 0);
    // a mode change during a flush reloads the blanking
    cyc(1, 1, 1, 1, 0);
    cyc(1, 2, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(50, 9000, 1, 0, 0);

    // counter saturates at all-ones
    for (int i = 0; i < 65540; i++) cyc(-32768, -32768, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("sat_cnt_hold_max", {16'b0, sat_cnt}, 32'd65535);
    chk("sat_flag_hold", {31'b0, sat_flag}, 32'd1);

    // asynchronous reset in the middle of valid traffic
    cyc(16384, 16384, 1, 0, 0);
    cyc(12000, -5000, 1, 0, 0);
    #2 rst = 0;
    #1;
    chk("arst_dout", {16'b0, dout}, 32'h0);
    chk("arst_dout_valid", {31'b0, dout_valid}, 32'h0);
    chk("arst_sat_flag", {31'b0, sat_flag}, 32'h0);
    chk("arst_sat_cnt", {16'b0, sat_cnt}, 32'h0);
    din_valid = 1;
    @(posedge clk); #1;
    chk("arst_hold_valid", {31'b0, dout_valid}, 32'h0);
    rst = 1;
    model_reset();
    repeat (3) cyc(777, 777, 0, 0, 0);
    cyc(-20000, 30000, 1, 0, 0);
    cyc(123, -456, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
